// File: rtl/dsp_nco_sweep.sv
// Frequency-sweep controller that drives dsp_nco's phase increment and enable,
// stepping from a start to a stop tuning word in sawtooth or triangle profile.
module dsp_nco_sweep #(
    parameter int PHI_WIDTH   = 32,
    parameter int DWELL_WIDTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   stop,
    input  logic [PHI_WIDTH-1:0]   f_start,
    input  logic [PHI_WIDTH-1:0]   f_stop,
    input  logic [PHI_WIDTH-1:0]   f_step,
    input  logic [DWELL_WIDTH-1:0] dwell,
    input  logic                   mode_tri,
    input  logic                   mode_cont,
    output logic [PHI_WIDTH-1:0]   phi_inc,
    output logic                   nco_en,
    output logic                   busy,
    output logic                   dir,
    output logic                   done,
    output logic                   err
);

    typedef enum logic [1:0] {IDLE, UP, DOWN} state_t;

    state_t                 state;
    logic [PHI_WIDTH-1:0]   fs_q, fe_q, st_q;
    logic [DWELL_WIDTH-1:0] dwell_q, cnt;
    logic                   tri_q, cont_q;

    // Add in one extra bit so a step past the top of the range clamps instead of wrapping.
    function automatic logic [PHI_WIDTH-1:0] sat_add(input logic [PHI_WIDTH-1:0] a,
                                                     input logic [PHI_WIDTH-1:0] b,
                                                     input logic [PHI_WIDTH-1:0] lim);
        logic [PHI_WIDTH:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return (sum > {1'b0, lim}) ? lim : sum[PHI_WIDTH-1:0];
    endfunction

    // Caller guarantees a >= floor, so a - floor never underflows.
    function automatic logic [PHI_WIDTH-1:0] sat_sub(input logic [PHI_WIDTH-1:0] a,
                                                     input logic [PHI_WIDTH-1:0] b,
                                                     input logic [PHI_WIDTH-1:0] floor);
        return (b > (a - floor)) ? floor : (a - b);
    endfunction

    logic [PHI_WIDTH-1:0] up_next, dn_next, turn_dn, turn_up;
    assign up_next = sat_add(phi_inc, st_q, fe_q);
    assign dn_next = sat_sub(phi_inc, st_q, fs_q);
    assign turn_dn = sat_sub(fe_q, st_q, fs_q);
    assign turn_up = sat_add(fs_q, st_q, fe_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            phi_inc <= '0;
            nco_en  <= 1'b0;
            busy    <= 1'b0;
            dir     <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            cnt     <= '0;
            fs_q    <= '0;
            fe_q    <= '0;
            st_q    <= '0;
            dwell_q <= '0;
            tri_q   <= 1'b0;
            cont_q  <= 1'b0;
        end else begin
            // NOTE: pulse outputs default low here and are overridden below; with
            // non-blocking assignments the last assignment in the block wins.
            done <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !stop) begin
                        if ((f_start <= f_stop) && (f_step != '0)) begin
                            fs_q    <= f_start;
                            fe_q    <= f_stop;
                            st_q    <= f_step;
                            dwell_q <= dwell;
                            tri_q   <= mode_tri;
                            cont_q  <= mode_cont;
                            phi_inc <= f_start;
                            cnt     <= dwell;
                            busy    <= 1'b1;
                            nco_en  <= 1'b1;
                            dir     <= 1'b0;
                            state   <= UP;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                UP, DOWN: begin
                    if (stop) begin
                        busy   <= 1'b0;
                        nco_en <= 1'b0;
                        state  <= IDLE;
                    end else if (cnt != '0) begin
                        cnt <= cnt - 1'b1;
                    end else begin
                        cnt <= dwell_q;
                        if (state == UP) begin
                            if (phi_inc != fe_q) begin
                                phi_inc <= up_next;
                            end else if (tri_q) begin
                                state   <= DOWN;
                                dir     <= 1'b1;
                                phi_inc <= turn_dn;
                            end else if (cont_q) begin
                                phi_inc <= fs_q;
                            end else begin
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                nco_en <= 1'b0;
                                state  <= IDLE;
                            end
                        end else begin
                            if (phi_inc != fs_q) begin
                                phi_inc <= dn_next;
                            end else if (cont_q) begin
                                state   <= UP;
                                dir     <= 1'b0;
                                phi_inc <= turn_up;
                            end else begin
                                done   <= 1'b1;
                                busy   <= 1'b0;
                                nco_en <= 1'b0;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
